// File: rtl/body_mc.sv
// body_mc: multi-cycle FETCH/DECODE/EXEC/MEM/WB core, one instruction in flight.
// Define BODY_MC_LUI_EN to decode lui; otherwise lui retires as a NOP.
module body_mc #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int NREG_LOG2 = 5
) (
    input  logic              clk,
    input  logic              trigger,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halt,
    output logic [31:0]       instret
);
    localparam int NREG = 2 ** NREG_LOG2;
    localparam logic [NREG_LOG2-1:0] LINK = '1;

`ifdef BODY_MC_LUI_EN
    localparam bit LUI_EN = 1'b1;
`else
    localparam bit LUI_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t               state;
    state_t               nxt;
    logic [PC_W-1:0]      pc;
    logic [31:0]          ir;
    logic [DATA_W-1:0]    regs [NREG];
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [DATA_W-1:0]    res;
    logic [NREG_LOG2-1:0] dst;

    logic [5:0]           op;
    logic [5:0]           fn;
    logic [15:0]          imm;
    logic [4:0]           shamt;
    logic [NREG_LOG2-1:0] rs;
    logic [NREG_LOG2-1:0] rt;
    logic [NREG_LOG2-1:0] rd;
    logic [DATA_W-1:0]    imm_sx;
    logic [DATA_W-1:0]    lui_val;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      br_tgt;
    logic [PC_W-1:0]      j_tgt;

    logic [DATA_W-1:0]    alu;
    logic [NREG_LOG2-1:0] wdst;
    logic [PC_W-1:0]      npc;

    assign op      = ir[31:26];
    assign fn      = ir[5:0];
    assign imm     = ir[15:0];
    assign shamt   = ir[10:6];
    assign rs      = NREG_LOG2'(ir[25:21]);
    assign rt      = NREG_LOG2'(ir[20:16]);
    assign rd      = NREG_LOG2'(ir[15:11]);
    assign imm_sx  = DATA_W'($signed(imm));
    assign lui_val = DATA_W'(imm) << (DATA_W - 16);
    assign pc_inc  = pc + PC_W'(1);
    assign br_tgt  = pc_inc + PC_W'($signed(imm));
    assign j_tgt   = PC_W'(ir[25:0]);

    // Execute-stage result, destination, next state and next PC
    always_comb begin
        alu  = '0;
        nxt  = S_FETCH;
        wdst = rt;
        npc  = pc_inc;
        unique case (op)
            OP_R: begin
                wdst = rd;
                nxt  = S_WB;
                unique case (fn)
                    F_ADD: alu = a + b;
                    F_SUB: alu = a - b;
                    F_AND: alu = a & b;
                    F_OR:  alu = a | b;
                    F_SLT: alu = DATA_W'($signed(a) < $signed(b));
                    F_SLL: alu = b << shamt;
                    F_SRL: alu = b >> shamt;
                    F_JR: begin
                        nxt = S_FETCH;
                        npc = PC_W'(a);
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            OP_ADDI: begin
                alu = a + imm_sx;
                nxt = S_WB;
            end
            OP_LW, OP_SW: begin
                alu = a + imm_sx;
                nxt = S_MEM;
            end
            OP_BEQ: if (a == b) npc = br_tgt;
            OP_BNE: if (a != b) npc = br_tgt;
            OP_J, OP_JAL: npc = j_tgt;
            OP_LUI: begin
                if (LUI_EN) begin
                    alu = lui_val;
                    nxt = S_WB;
                end
            end
            OP_HALT: nxt = S_HALT;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge trigger) begin
        if (!trigger) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            res     <= '0;
            dst     <= '0;
            instret <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res   <= alu;
                    dst   <= wdst;
                    state <= nxt;
                    if (nxt == S_FETCH) begin
                        pc      <= npc;
                        instret <= instret + 32'd1;
                    end
                    if (op == OP_JAL) regs[LINK] <= DATA_W'(pc_inc);
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (dmem_we) begin
                            pc      <= pc_inc;
                            instret <= instret + 32'd1;
                            state   <= S_FETCH;
                        end else begin
                            res   <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dst != '0) regs[dst] <= res;
                    pc      <= pc_inc;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Fetch request is masked while reset is held so it drops immediately
    assign imem_req   = trigger && (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && (op == OP_SW);
    assign dmem_addr  = PC_W'(res);
    assign dmem_wdata = b;
    assign halt       = (state == S_HALT);

endmodule

// File: tb/tb_body_mc.sv
// tb_body_mc: directed programs against an instruction-level model of body_mc.
// Honours BODY_MC_LUI_EN the same way the design does.
module tb_body_mc;
    logic        clk = 1'b0;
    logic        trigger;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        halt;
    logic [31:0] instret;

`ifdef BODY_MC_LUI_EN
    localparam bit LUI_EN = 1'b1;
`else
    localparam bit LUI_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    body_mc dut (
        .clk        (clk),
        .trigger    (trigger),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .halt       (halt),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    assign imem_rdata = imem[imem_addr[7:0]];
    assign dmem_rdata = dmem[dmem_addr[7:0]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs,
                                          input int rt, input int rd, input int sh);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs,
                                          input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    // Instruction-level model: each fetched word is executed in one step
    logic [31:0] mr [32];
    logic [31:0] mmem [256];
    logic [31:0] mpc;
    logic [31:0] minstret;
    logic        mhalted;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          hcnt;
    logic [31:0] fetch_log [$];

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mr[i] = '0;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = '0;
            dmem[i] = '0;
        end
        mpc      = '0;
        minstret = '0;
        mhalted  = 1'b0;
        m_valid  = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        hcnt     = 0;
        fetch_log.delete();
    endtask

    task automatic mdl_step(input logic [31:0] ins);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          rs, rt, rd, sh, wd;
        logic [31:0] va, vb, sx, wv, nx;
        op = ins[31:26];
        fn = ins[5:0];
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        sh = int'(ins[10:6]);
        va = mr[rs];
        vb = mr[rt];
        sx = {{16{ins[15]}}, ins[15:0]};
        nx = mpc + 1;
        wd = 0;
        wv = '0;
        case (op)
            OP_R: begin
                case (fn)
                    F_ADD: begin wv = va + vb; wd = rd; end
                    F_SUB: begin wv = va - vb; wd = rd; end
                    F_AND: begin wv = va & vb; wd = rd; end
                    F_OR:  begin wv = va | vb; wd = rd; end
                    F_SLT: begin
                        wv = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                        wd = rd;
                    end
                    F_SLL: begin wv = vb << sh; wd = rd; end
                    F_SRL: begin wv = vb >> sh; wd = rd; end
                    F_JR:  nx = va;
                    default: ;
                endcase
            end
            OP_ADDI: begin wv = va + sx; wd = rt; end
            OP_LW: begin
                m_valid = 1'b1;
                m_we    = 1'b0;
                m_addr  = va + sx;
                m_wdata = '0;
                wv      = mmem[m_addr[7:0]];
                wd      = rt;
            end
            OP_SW: begin
                m_valid = 1'b1;
                m_we    = 1'b1;
                m_addr  = va + sx;
                m_wdata = vb;
            end
            OP_BEQ: if (va == vb) nx = mpc + 1 + sx;
            OP_BNE: if (va != vb) nx = mpc + 1 + sx;
            OP_J:   nx = {6'b0, ins[25:0]};
            OP_JAL: begin
                nx = {6'b0, ins[25:0]};
                wv = mpc + 1;
                wd = 31;
            end
            OP_LUI: if (LUI_EN) begin wv = {ins[15:0], 16'h0}; wd = rt; end
            OP_HALT: mhalted = 1'b1;
            default: ;
        endcase
        if (wd != 0) mr[wd] = wv;
        if (!mhalted) begin
            mpc      = nx;
            minstret = minstret + 1;
        end
    endtask

    // Compare process: DUT outputs against the model on every cycle
    always @(negedge clk) begin
        if (!trigger) begin
            chk("rst_imem_req", {31'b0, imem_req}, 0);
            chk("rst_dmem_req", {31'b0, dmem_req}, 0);
            chk("rst_dmem_we", {31'b0, dmem_we}, 0);
            chk("rst_halt", {31'b0, halt}, 0);
            chk("rst_instret", instret, 0);
            mdl_reset();
        end else begin
            if (mhalted) hcnt++;
            if (imem_req || dmem_req)
                chk("req_overlap", {31'b0, imem_req & dmem_req}, 0);
            if (imem_req) begin
                chk("fetch_pc", imem_addr, mpc);
                chk("mem_skipped", {31'b0, m_valid}, 0);
                if (imem_ready) begin
                    chk("instret_at_fetch", instret, minstret);
                    fetch_log.push_back(imem_addr);
                    mdl_step(imem[mpc[7:0]]);
                    hcnt = 0;
                end
            end
            if (dmem_req) begin
                chk("dmem_expected", {31'b0, m_valid}, 1);
                chk("dmem_addr", dmem_addr, m_addr);
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_we});
                if (m_we) chk("dmem_wdata", dmem_wdata, m_wdata);
                if (dmem_ready) begin
                    if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
                    if (m_we) mmem[m_addr[7:0]] = m_wdata;
                    m_valid = 1'b0;
                end
            end
            if (mhalted && hcnt >= 3) chk("halt_asserted", {31'b0, halt}, 1);
            if (halt) begin
                chk("halt_expected", {31'b0, mhalted}, 1);
                chk("halt_no_req", {31'b0, imem_req | dmem_req}, 0);
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 26'h0};
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #1 trigger = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        clear_imem();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 trigger = 1'b1;
    endtask

    task automatic run_to_halt(input int maxc);
        int c;
        c = 0;
        while (halt !== 1'b1 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("halt_reached", {31'b0, halt}, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_dmem(input int maxc);
        int c;
        c = 0;
        while (dmem_req !== 1'b1 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("dmem_req_seen", {31'b0, dmem_req}, 1);
    endtask

    logic [31:0] exp_log [6];

    initial begin
        trigger    = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        clear_imem();

        // A: addi/addi/add timing, then store the sum
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_ADDI, 0, 2, -3);
        imem[2] = enc_r(F_ADD, 1, 2, 3, 0);
        imem[3] = enc_i(OP_SW, 0, 3, 8);
        release_reset();
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("a_instret_11cyc", instret, 2);
        @(posedge clk);
        @(negedge clk);
        chk("a_instret_12cyc", instret, 3);
        run_to_halt(100);
        chk("a_sum_stored", dmem[8], 32'd2);
        chk("a_instret_halt", instret, 4);

        // B: fetch stall of 4 cycles, store stall of 3 cycles
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 0, 1, 7);
        imem[1] = enc_i(OP_SW, 0, 1, 0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        release_reset();
        repeat (4) begin
            @(negedge clk);
            chk("b_stall_req", {31'b0, imem_req}, 1);
            chk("b_stall_addr", imem_addr, 0);
        end
        @(posedge clk);
        #1 imem_ready = 1'b1;
        wait_dmem(50);
        repeat (3) @(posedge clk);
        #1 dmem_ready = 1'b1;
        run_to_halt(100);
        chk("b_store", dmem[0], 32'd7);
        chk("b_instret", instret, 2);
        chk("b_fetches", 32'(fetch_log.size()), 3);

        // C: store then load back through memory
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_SW, 0, 1, 4);
        imem[2] = enc_i(OP_LW, 0, 4, 4);
        imem[3] = enc_i(OP_SW, 0, 4, 5);
        release_reset();
        run_to_halt(100);
        chk("c_sw_mem4", dmem[4], 32'd5);
        chk("c_lw_copy", dmem[5], 32'd5);
        chk("c_instret", instret, 4);

        // D: self-loop beq at PC 7
        hold_reset();
        imem[0] = enc_j(OP_J, 7);
        imem[7] = enc_i(OP_BEQ, 0, 0, -1);
        release_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("d_fetch_count", {31'b0, fetch_log.size() >= 4}, 1);
        exp_log[0] = 0;
        exp_log[1] = 7;
        exp_log[2] = 7;
        exp_log[3] = 7;
        for (int i = 0; i < 4; i++) chk("d_fetch_addr", fetch_log[i], exp_log[i]);

        // E: bne not taken, j, jal, bne taken
        hold_reset();
        imem[0]     = enc_i(OP_BNE, 0, 0, 3);
        imem[1]     = enc_j(OP_J, 9);
        imem[9]     = enc_j(OP_JAL, 'h20);
        imem['h20]  = enc_i(OP_SW, 0, 31, 0);
        imem['h21]  = enc_i(OP_BNE, 31, 0, 2);
        imem['h22]  = enc_i(OP_ADDI, 0, 1, 1);
        release_reset();
        run_to_halt(100);
        exp_log[0] = 0;
        exp_log[1] = 1;
        exp_log[2] = 9;
        exp_log[3] = 'h20;
        exp_log[4] = 'h21;
        exp_log[5] = 'h24;
        chk("e_fetch_count", 32'(fetch_log.size()), 6);
        for (int i = 0; i < 6; i++) chk("e_fetch_addr", fetch_log[i], exp_log[i]);
        chk("e_link", dmem[0], 32'd10);
        chk("e_instret", instret, 5);

        // F: reset pulse in the middle of a stalled store
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 0, 1, 9);
        imem[1] = enc_i(OP_SW, 0, 1, 3);
        dmem_ready = 1'b0;
        release_reset();
        wait_dmem(50);
        repeat (2) @(posedge clk);
        #1 trigger = 1'b0;
        #1;
        chk("f_dmem_req_drop", {31'b0, dmem_req}, 0);
        chk("f_dmem_we_drop", {31'b0, dmem_we}, 0);
        chk("f_imem_req_rst", {31'b0, imem_req}, 0);
        chk("f_instret_rst", instret, 0);
        chk("f_no_write", dmem[3], 0);
        @(posedge clk);
        #1 trigger = 1'b1;
        dmem_ready = 1'b1;
        run_to_halt(100);
        chk("f_first_fetch", fetch_log[0], 0);
        chk("f_fetches", 32'(fetch_log.size()), 3);
        chk("f_store", dmem[3], 32'd9);
        chk("f_instret", instret, 2);

        // G: lui with or without the option
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 0, 5, 77);
        imem[1] = enc_i(OP_LUI, 0, 5, 'h1234);
        imem[2] = enc_i(OP_SW, 0, 5, 0);
        release_reset();
        run_to_halt(100);
        chk("g_lui", dmem[0], LUI_EN ? 32'h1234_0000 : 32'd77);
        chk("g_instret", instret, 3);

        // H: ALU ops, unknown codes, jr, write to $0
        hold_reset();
        imem[0]  = enc_i(OP_ADDI, 0, 1, -8);
        imem[1]  = enc_i(OP_ADDI, 0, 2, 3);
        imem[2]  = enc_r(F_SUB, 1, 2, 3, 0);
        imem[3]  = enc_r(F_AND, 1, 2, 4, 0);
        imem[4]  = enc_r(F_OR, 1, 2, 5, 0);
        imem[5]  = enc_r(F_SLT, 1, 2, 6, 0);
        imem[6]  = enc_r(F_SLL, 0, 2, 7, 4);
        imem[7]  = enc_r(F_SRL, 0, 1, 8, 28);
        imem[8]  = 32'hF800_0000;
        imem[9]  = enc_r(6'h3F, 2, 2, 1, 0);
        imem[10] = enc_i(OP_ADDI, 0, 9, 13);
        imem[11] = enc_r(F_JR, 9, 0, 0, 0);
        imem[13] = enc_i(OP_SW, 0, 3, 16);
        imem[14] = enc_i(OP_SW, 0, 4, 17);
        imem[15] = enc_i(OP_SW, 0, 5, 18);
        imem[16] = enc_i(OP_SW, 0, 6, 19);
        imem[17] = enc_i(OP_SW, 0, 7, 20);
        imem[18] = enc_i(OP_SW, 0, 8, 21);
        imem[19] = enc_i(OP_SW, 0, 1, 22);
        imem[20] = enc_i(OP_ADDI, 0, 0, 5);
        imem[21] = enc_i(OP_SW, 0, 0, 23);
        release_reset();
        run_to_halt(300);
        chk("h_sub", dmem[16], 32'hFFFF_FFF5);
        chk("h_and", dmem[17], 32'h0000_0000);
        chk("h_or", dmem[18], 32'hFFFF_FFFB);
        chk("h_slt", dmem[19], 32'd1);
        chk("h_sll", dmem[20], 32'd48);
        chk("h_srl", dmem[21], 32'd15);
        chk("h_bad_funct", dmem[22], 32'hFFFF_FFF8);
        chk("h_reg0", dmem[23], 32'd0);
        chk("h_instret", instret, 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
